clkgen_multi: RTL

CLKGEN_MULTI -- requirements
Module: clkgen_multi

---
 rtl/clkgen_pkg.sv | 23 ++
 rtl/clkgen_chan.sv | 69 ++++++
 rtl/clkgen_multi.sv | 115 +++++++++++
 3 files changed

// File: rtl/clkgen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clkgen_pkg
// Purpose  : Shared state encoding, constants and helpers for clkgen_multi.
// Revision : 1.0 - initial release
// ============================================================================
package clkgen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCK   = 2'd2
  } state_e;

  localparam int D_MIN = 2;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int settle_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clkgen_chan.sv
`default_nettype none
// ============================================================================
// Module   : clkgen_chan
// Purpose  : One divided-clock channel: phase counter, clock and enable pulse.
// Revision : 1.0 - initial release
// ============================================================================
module clkgen_chan
  import clkgen_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int PH_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [PH_W-1:0]  ph_i,
  output logic             outclk_o,
  output logic             outce_o
);

  localparam int CW = (DIV_W > PH_W) ? DIV_W : PH_W;
  localparam logic [DIV_W-1:0] c_one  = DIV_W'(1);
  localparam logic [DIV_W-1:0] c_dmin = DIV_W'(D_MIN);

  logic [DIV_W-1:0] d_eff, p_eff, half;
  logic [CW-1:0]    d_ext, p_ext;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             outclk_q, outclk_d;
  logic             outce_q, outce_d;

  always_comb begin
    d_eff = (div_i < c_dmin) ? c_dmin : div_i;
    d_ext = CW'(d_eff);
    p_ext = CW'(ph_i);
    p_eff = (p_ext < d_ext) ? DIV_W'(p_ext) : '0;
    // ceil(D/2) as floor(D/2)+lsb keeps the sum inside DIV_W bits
    half  = (d_eff >> 1) + (d_eff[0] ? c_one : '0);

    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = p_eff;
    end else if (run_i) begin
      cnt_d = (cnt_q == d_eff - c_one) ? '0 : cnt_q + c_one;
    end

    // Outputs are registered from the next count so they line up with cnt_q.
    outclk_d = run_i && (cnt_d < half);
    outce_d  = run_i && (cnt_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      outclk_q <= 1'b0;
      outce_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      outclk_q <= outclk_d;
      outce_q  <= outce_d;
    end
  end

  assign outclk_o = outclk_q;
  assign outce_o  = outce_q;

endmodule
`default_nettype wire

// File: rtl/clkgen_multi.sv
`default_nettype none
// ============================================================================
// Module   : clkgen_multi
// Purpose  : Multi-channel phase-aligned clock divider with settle/lock FSM.
// Revision : 1.0 - initial release
// ============================================================================
module clkgen_multi
  import clkgen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int PH_W        = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cfg_load,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  input  logic [NUM_CH*PH_W-1:0]  ph_cfg,
  output logic [NUM_CH-1:0]       outclk,
  output logic [NUM_CH-1:0]       outce,
  output logic                    locked
);

  localparam int SETTLE_W = settle_w(LOCK_CYCLES);
  localparam logic [SETTLE_W-1:0] c_settle_last = SETTLE_W'(LOCK_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] c_settle_one  = SETTLE_W'(1);
  localparam logic [DIV_W-1:0]    c_div_rst     = DIV_W'(D_MIN);

  state_e                    state_q, state_d;
  logic [SETTLE_W-1:0]       settle_q, settle_d;
  logic [NUM_CH*DIV_W-1:0]   div_q, div_d;
  logic [NUM_CH*PH_W-1:0]    ph_q, ph_d;
  logic                      chan_load, chan_run;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= '0;
      div_q    <= {NUM_CH{c_div_rst}};
      ph_q     <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      div_q    <= div_d;
      ph_q     <= ph_d;
    end
  end

  always_comb begin
    div_d    = cfg_load ? div_cfg : div_q;
    ph_d     = cfg_load ? ph_cfg  : ph_q;
    state_d  = state_q;
    settle_d = settle_q;

    unique case (state_q)
      IDLE: begin
        state_d  = SETTLE;
        settle_d = '0;
      end
      SETTLE: begin
        if (cfg_load) begin
          settle_d = '0;
        end else if (settle_q == c_settle_last) begin
          state_d  = LOCK;
          settle_d = '0;
        end else begin
          settle_d = settle_q + c_settle_one;
        end
      end
      LOCK: begin
        if (cfg_load) begin
          state_d  = SETTLE;
          settle_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        settle_d = '0;
      end
    endcase

    // Dropping en overrides every transition above.
    if (!en) begin
      state_d  = IDLE;
      settle_d = '0;
    end

    // Counters sit at their phase offset in IDLE and realign on each SETTLE start.
    chan_load = (state_d == IDLE) ||
                ((state_d == SETTLE) && ((state_q != SETTLE) || cfg_load));
    chan_run  = (state_d != IDLE);
  end

  assign locked = (state_q == LOCK);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clkgen_chan #(
      .DIV_W (DIV_W),
      .PH_W  (PH_W)
    ) u_chan (
      .clk_i    (refclk),
      .rst_i    (rst),
      .load_i   (chan_load),
      .run_i    (chan_run),
      .div_i    (div_d[i*DIV_W +: DIV_W]),
      .ph_i     (ph_d[i*PH_W +: PH_W]),
      .outclk_o (outclk[i]),
      .outce_o  (outce[i])
    );
  end

endmodule
`default_nettype wire
